// File: rtl/dest_reg_pipe_pkg.sv
// ----------------------------------------------------------------------------
// dest_reg_pipe_pkg
//   Shared definitions for the destination-register pipeline and the EX-stage
//   ALU-input muxes: the forwarding select encoding and the default
//   register-number width.
//   No ports (package).
// ----------------------------------------------------------------------------
package dest_reg_pipe_pkg;

  // Default register-number width (32 architectural registers).
  localparam int DEFAULT_REG_ADDR_W = 5;

  // Forwarding select encoding seen by the ALU operand muxes.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 2'b00;  // operand from the ID/EX register
  localparam fwd_sel_t FWD_WB   = 2'b01;  // operand from the MEM/WB result
  localparam fwd_sel_t FWD_MEM  = 2'b10;  // operand from the EX/MEM result

endpackage : dest_reg_pipe_pkg

// File: rtl/dest_reg_pipe_fwd_select.sv
// ----------------------------------------------------------------------------
// fwd_select
//   Purely combinational forwarding select for one ALU operand. Compares the
//   operand's source register against the EX/MEM and MEM/WB destinations.
//   Ports:
//     i_src      in   REG_ADDR_W  source register of the EX-stage operand
//     i_mem_dest in   REG_ADDR_W  EX/MEM destination register
//     i_mem_we   in   1           EX/MEM register-write enable
//     i_wb_dest  in   REG_ADDR_W  MEM/WB destination register
//     i_wb_we    in   1           MEM/WB register-write enable
//     o_sel      out  2           FWD_MEM / FWD_WB / FWD_NONE
// ----------------------------------------------------------------------------
module fwd_select
  import dest_reg_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [REG_ADDR_W-1:0] i_mem_dest,
  input  logic                  i_mem_we,
  input  logic [REG_ADDR_W-1:0] i_wb_dest,
  input  logic                  i_wb_we,
  output fwd_sel_t              o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Register 0 is hard-wired to zero, so a write to it never produces a value
  // worth forwarding even when the write enable is set.
  assign w_mem_hit = i_mem_we && (i_mem_dest != '0) && (i_mem_dest == i_src);
  assign w_wb_hit  = i_wb_we  && (i_wb_dest  != '0) && (i_wb_dest  == i_src);

  // The EX/MEM result is younger than the MEM/WB result, so it wins when both
  // stages target the same register.
  always_comb begin
    o_sel = FWD_NONE;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule : fwd_select

// File: rtl/dest_reg_pipe.sv
// ----------------------------------------------------------------------------
// dest_reg_pipe
//   Carries the EX-stage destination register number and its write/load
//   controls through the EX/MEM and MEM/WB pipeline registers, derives the
//   forwarding selects for both ALU operands, raises the load-use stall and
//   counts stall cycles (saturating) for performance debug.
//   Ports:
//     clk             in   1           rising-edge clock
//     reset           in   1           synchronous, active-high
//     dest_in         in   DEST_IN_W   RegDst mux output; only low REG_ADDR_W bits used
//     ex_reg_write    in   1           EX instruction writes the register file
//     ex_mem_read     in   1           EX instruction is a load
//     ex_rs, ex_rt    in   REG_ADDR_W  EX source registers (forwarding)
//     id_rs, id_rt    in   REG_ADDR_W  ID source registers (load-use detection)
//     hold            in   1           freeze both pipeline stages
//     flush_ex        in   1           bubble into EX/MEM
//     mem_dest        out  REG_ADDR_W  EX/MEM destination
//     mem_reg_write   out  1           EX/MEM write enable
//     mem_mem_read    out  1           EX/MEM load flag
//     wb_dest         out  REG_ADDR_W  MEM/WB destination (register-file write address)
//     wb_reg_write    out  1           MEM/WB write enable
//     forward_a       out  2           ALU operand A select
//     forward_b       out  2           ALU operand B select
//     load_use_stall  out  1           stall PC and IF/ID, bubble ID/EX
//     stall_count     out  CNT_W       saturating count of stall cycles
// ----------------------------------------------------------------------------
module dest_reg_pipe
  import dest_reg_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int DEST_IN_W  = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEST_IN_W-1:0]  dest_in,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  hold,
  input  logic                  flush_ex,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  wb_reg_write,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      stall_count
);

  // EX/MEM stage
  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic                  r_mem_we;
  logic                  r_mem_rd;

  // MEM/WB stage
  logic [REG_ADDR_W-1:0] r_wb_dest;
  logic                  r_wb_we;

  logic [CNT_W-1:0]      r_stall_count;

  logic [REG_ADDR_W-1:0] w_ex_dest;
  logic                  w_load_use;
  logic                  w_cnt_saturated;
  fwd_sel_t              w_fwd_a;
  fwd_sel_t              w_fwd_b;
  logic                  w_unused_dest_in;

  // The RegDst mux is full word width; only the register-number field matters.
  assign w_ex_dest        = dest_in[REG_ADDR_W-1:0];
  assign w_unused_dest_in = ^dest_in;

  // A load in EX whose destination feeds either ID source cannot be forwarded
  // in time. Register 0 is excluded because it never carries a real result.
  assign w_load_use = ex_mem_read && ex_reg_write && (w_ex_dest != '0) &&
                      ((w_ex_dest == id_rs) || (w_ex_dest == id_rt));

  // Pipeline advance. Hold freezes both stages and masks a concurrent flush;
  // a flush only bubbles EX/MEM while the older instruction still moves on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_dest <= '0;
      r_mem_we   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_wb_dest  <= '0;
      r_wb_we    <= 1'b0;
    end else if (!hold) begin
      r_wb_dest <= r_mem_dest;
      r_wb_we   <= r_mem_we;
      if (flush_ex) begin
        r_mem_dest <= '0;
        r_mem_we   <= 1'b0;
        r_mem_rd   <= 1'b0;
      end else begin
        r_mem_dest <= w_ex_dest;
        r_mem_we   <= ex_reg_write;
        r_mem_rd   <= ex_mem_read;
      end
    end
  end

  assign w_cnt_saturated = (r_stall_count == {CNT_W{1'b1}});

  // Stall-cycle counter runs independently of hold so stalled cycles spent
  // frozen are still counted; it sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_load_use && !w_cnt_saturated) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  fwd_select #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .i_src      (ex_rs),
    .i_mem_dest (r_mem_dest),
    .i_mem_we   (r_mem_we),
    .i_wb_dest  (r_wb_dest),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_fwd_a)
  );

  fwd_select #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .i_src      (ex_rt),
    .i_mem_dest (r_mem_dest),
    .i_mem_we   (r_mem_we),
    .i_wb_dest  (r_wb_dest),
    .i_wb_we    (r_wb_we),
    .o_sel      (w_fwd_b)
  );

  assign mem_dest       = r_mem_dest;
  assign mem_reg_write  = r_mem_we;
  assign mem_mem_read   = r_mem_rd;
  assign wb_dest        = r_wb_dest;
  assign wb_reg_write   = r_wb_we;
  assign forward_a      = w_fwd_a;
  assign forward_b      = w_fwd_b;
  assign load_use_stall = w_load_use;
  assign stall_count    = r_stall_count;

endmodule : dest_reg_pipe

// File: tb/tb_dest_reg_pipe.sv
// ----------------------------------------------------------------------------
// tb_dest_reg_pipe
//   Self-checking bench for dest_reg_pipe. A driver issues directed and random
//   stimulus on the falling edge and pushes the expected outputs into a
//   scoreboard queue; a monitor pops and compares shortly after. A second
//   instance with a 3-bit counter exercises counter saturation.
// ----------------------------------------------------------------------------
module tb_dest_reg_pipe;

  localparam int RW  = 5;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int SCW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] dest_in;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [RW-1:0] ex_rs, ex_rt, id_rs, id_rt;
  logic          hold;
  logic          flush_ex;

  logic [RW-1:0] mem_dest, wb_dest;
  logic          mem_reg_write, mem_mem_read, wb_reg_write;
  logic [1:0]    forward_a, forward_b;
  logic          load_use_stall;
  logic [CW-1:0] stall_count;

  logic [RW-1:0]  sMemDest, sWbDest;
  logic           sMemWe, sMemRd, sWbWe;
  logic [1:0]     sFwdA, sFwdB;
  logic           sStall;
  logic [SCW-1:0] sCount;

  always #5 clk = ~clk;

  dest_reg_pipe #(.REG_ADDR_W(RW), .DEST_IN_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .dest_in(dest_in),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .hold(hold), .flush_ex(flush_ex),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
    .forward_a(forward_a), .forward_b(forward_b),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  dest_reg_pipe #(.REG_ADDR_W(RW), .DEST_IN_W(DW), .CNT_W(SCW)) u_dut_small (
    .clk(clk), .reset(reset), .dest_in(dest_in),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .hold(hold), .flush_ex(flush_ex),
    .mem_dest(sMemDest), .mem_reg_write(sMemWe), .mem_mem_read(sMemRd),
    .wb_dest(sWbDest), .wb_reg_write(sWbWe),
    .forward_a(sFwdA), .forward_b(sFwdB),
    .load_use_stall(sStall), .stall_count(sCount)
  );

  typedef struct {
    logic [RW-1:0] dest;
    logic          we;
    logic          rd;
  } stage_t;

  typedef struct {
    logic [RW-1:0]  memDest;
    logic           memWe;
    logic           memRd;
    logic [RW-1:0]  wbDest;
    logic           wbWe;
    logic [1:0]     fwdA;
    logic [1:0]     fwdB;
    logic           stall;
    logic [CW-1:0]  cnt;
    logic [SCW-1:0] cntSmall;
  } expect_t;

  expect_t scoreboard[$];

  // Reference model: pipe[0] is the EX/MEM stage, pipe[1] is MEM/WB.
  stage_t pipe[2];
  int     cntModel;
  int     cntSmallModel;

  int checks = 0;
  int errors = 0;

  // Youngest stage that writes a non-zero matching register supplies the value.
  function automatic logic [1:0] fwdFor(input logic [RW-1:0] src);
    for (int s = 0; s < 2; s++) begin
      if (pipe[s].we && pipe[s].dest != 0 && pipe[s].dest == src)
        return (s == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [DW-1:0] dIn,
                               input logic we, input logic rd,
                               input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                               input logic [RW-1:0] irs, input logic [RW-1:0] irt,
                               input logic hld, input logic fl, input bit track);
    expect_t       e;
    logic [RW-1:0] exDest;
    logic          stallExp;
    @(negedge clk);
    reset = rst; dest_in = dIn; ex_reg_write = we; ex_mem_read = rd;
    ex_rs = rs; ex_rt = rt; id_rs = irs; id_rt = irt; hold = hld; flush_ex = fl;
    exDest   = dIn[RW-1:0];
    stallExp = rd && we && (exDest != 0) && (exDest == irs || exDest == irt);
    if (track) begin
      e.memDest  = pipe[0].dest;
      e.memWe    = pipe[0].we;
      e.memRd    = pipe[0].rd;
      e.wbDest   = pipe[1].dest;
      e.wbWe     = pipe[1].we;
      e.fwdA     = fwdFor(rs);
      e.fwdB     = fwdFor(rt);
      e.stall    = stallExp;
      e.cnt      = CW'(cntModel);
      e.cntSmall = SCW'(cntSmallModel);
      scoreboard.push_back(e);
    end
    // State after the coming rising edge.
    if (rst) begin
      pipe[0] = '{dest: '0, we: 1'b0, rd: 1'b0};
      pipe[1] = '{dest: '0, we: 1'b0, rd: 1'b0};
      cntModel = 0;
      cntSmallModel = 0;
    end else begin
      if (stallExp) begin
        if (cntModel < (1 << CW) - 1) cntModel++;
        if (cntSmallModel < (1 << SCW) - 1) cntSmallModel++;
      end
      if (!hld) begin
        pipe[1] = '{dest: pipe[0].dest, we: pipe[0].we, rd: 1'b0};
        if (fl) pipe[0] = '{dest: '0, we: 1'b0, rd: 1'b0};
        else    pipe[0] = '{dest: exDest, we: we, rd: rd};
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT outputs against the oldest pending expectation.
  always @(negedge clk) begin
    expect_t e;
    #2;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkOutput("mem_dest",       32'(mem_dest),       32'(e.memDest));
      checkOutput("mem_reg_write",  32'(mem_reg_write),  32'(e.memWe));
      checkOutput("mem_mem_read",   32'(mem_mem_read),   32'(e.memRd));
      checkOutput("wb_dest",        32'(wb_dest),        32'(e.wbDest));
      checkOutput("wb_reg_write",   32'(wb_reg_write),   32'(e.wbWe));
      checkOutput("forward_a",      32'(forward_a),      32'(e.fwdA));
      checkOutput("forward_b",      32'(forward_b),      32'(e.fwdB));
      checkOutput("load_use_stall", 32'(load_use_stall), 32'(e.stall));
      checkOutput("stall_count",    32'(stall_count),    32'(e.cnt));
      checkOutput("small_mem_dest", 32'(sMemDest),       32'(e.memDest));
      checkOutput("small_wb",       32'({sWbDest, sWbWe, sMemWe, sMemRd}),
                  32'({e.wbDest, e.wbWe, e.memWe, e.memRd}));
      checkOutput("small_fwd",      32'({sFwdA, sFwdB, sStall}),
                  32'({e.fwdA, e.fwdB, e.stall}));
      checkOutput("small_stall_count", 32'(sCount), 32'(e.cntSmall));
    end
  end

  initial begin
    logic [DW-1:0] d;
    int            guard;
    reset = 1'b1; dest_in = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0; hold = 1'b0; flush_ex = 1'b0;

    // Initial reset: DUT state is unknown before this edge, so nothing is checked.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Pass-through of destination 9 (upper bits must be ignored too).
    applyStimulus(0, 32'h0000_0009, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'hFFFF_FFE0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Forwarding: both stages hold 5, then only WB, then dest 0 never forwards.
    applyStimulus(0, 32'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd5, 0, 0, 5, 5, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd0, 1, 0, 5, 5, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Load-use on id_rt and id_rs, then destination 0 which must not stall.
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 32'd8, 1, 1, 0, 0, 3, 8, 0, 0, 1);
    applyStimulus(0, 32'd8, 1, 1, 0, 0, 8, 3, 0, 0, 1);
    applyStimulus(0, 32'd0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd7, 1, 0, 0, 0, 7, 7, 0, 0, 1);

    // Hold with flush is a pure freeze; then a flush alone bubbles EX/MEM.
    applyStimulus(0, 32'd12, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'd13, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 32'd14, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 32'd15, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Saturation: the 3-bit counter sticks at 7; hold must not freeze counting.
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 32'd9, 1, 1, 0, 0, 9, 0, (i % 3 == 0), 0, 1);

    // Reset mid-stream with stages loaded, overriding hold and flush.
    applyStimulus(0, 32'd21, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 32'd22, 1, 1, 21, 21, 22, 22, 1, 1, 1);
    applyStimulus(0, 32'd0, 0, 0, 21, 21, 0, 0, 0, 0, 1);

    // Random traffic over a small register range so matches are frequent.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom;
      d[RW-1:0] = RW'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 199) == 0), d,
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                    RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
                    RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), 1);
    end

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (scoreboard.size() > 0 && guard < 10) begin
      @(negedge clk);
      #4;
      guard++;
    end
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dest_reg_pipe
